// File: rtl/serial_subtractor_if.sv
// Start/busy/done handshake bundle for the bit-serial subtractor.
// The master issues operands; the slave returns the registered result.
interface serial_subtractor_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             borrow_out;

    modport master (
        output start, a, b, bin,
        input  busy, done, diff, borrow_out
    );

    modport slave (
        input  start, a, b, bin,
        output busy, done, diff, borrow_out
    );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor: a - b - bin, LSB first, one full-subtractor step per clock.
// The result and final borrow are held until the next operation completes.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    serial_subtractor_if.slave  bus
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           r_state;
    state_t           w_next_state;

    logic [WIDTH-1:0] r_a_sh;
    logic [WIDTH-1:0] r_b_sh;
    logic [WIDTH-2:0] r_part;
    logic             r_br;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_diff;
    logic             r_borrow;

    logic             w_d;
    logic             w_borrow_next;
    logic             w_last;
    logic             w_accept;
    logic [WIDTH-1:0] w_part_next;

    // One full-subtractor cell fed by the operand LSBs and the registered borrow.
    assign w_d           = r_a_sh[0] ^ r_b_sh[0] ^ r_br;
    assign w_borrow_next = (~r_a_sh[0] & r_b_sh[0]) | (~(r_a_sh[0] ^ r_b_sh[0]) & r_br);
    assign w_last        = (r_cnt == LAST_STEP);
    assign w_accept      = (r_state == S_IDLE) && bus.start;

    // The partial result only needs WIDTH-1 bits; the last bit joins it on the completing edge.
    assign w_part_next   = {w_d, r_part};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_next_state = S_RUN;
                end
            end
            S_RUN: begin
                if (w_last) begin
                    w_next_state = S_DONE;
                end
            end
            S_DONE: begin
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a_sh   <= '0;
            r_b_sh   <= '0;
            r_part   <= '0;
            r_br     <= 1'b0;
            r_cnt    <= '0;
            r_diff   <= '0;
            r_borrow <= 1'b0;
        end else if (w_accept) begin
            r_a_sh <= bus.a;
            r_b_sh <= bus.b;
            r_br   <= bus.bin;
            r_cnt  <= '0;
        end else if (r_state == S_RUN) begin
            r_a_sh <= r_a_sh >> 1;
            r_b_sh <= r_b_sh >> 1;
            r_br   <= w_borrow_next;
            r_part <= w_part_next[WIDTH-1:1];
            r_cnt  <= r_cnt + CNT_W'(1);
            if (w_last) begin
                r_diff   <= w_part_next;
                r_borrow <= w_borrow_next;
            end
        end
    end

    assign bus.busy       = (r_state == S_RUN);
    assign bus.done       = (r_state == S_DONE);
    assign bus.diff       = r_diff;
    assign bus.borrow_out = r_borrow;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed scoreboard bench for serial_subtractor at WIDTH=8, plus an exhaustive WIDTH=4 sweep.
module tb_serial_subtractor;

    typedef struct {
        logic [7:0] d;
        logic       br;
    } exp_t;

    logic clk;
    logic rst_n;

    int   checks;
    int   failures;
    int   doneCount8;
    int   doneCount4;
    exp_t q8[$];
    exp_t q4[$];
    exp_t lastExp4;

    serial_subtractor_if #(.WIDTH(8)) if8 ();
    serial_subtractor_if #(.WIDTH(4)) if4 ();

    serial_subtractor #(.WIDTH(8)) dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if8)
    );

    serial_subtractor #(.WIDTH(4)) dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic exp_t model8(input logic [7:0] a, input logic [7:0] b, input logic bin);
        logic [8:0] r;
        exp_t e;
        r    = {1'b0, a} - {1'b0, b} - {8'd0, bin};
        e.d  = r[7:0];
        e.br = r[8];
        return e;
    endfunction

    // Drive one accepted start; returns just after the accepting edge.
    task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b, input logic bin, input bit expectResult);
        if8.start = 1'b1;
        if8.a     = a;
        if8.b     = b;
        if8.bin   = bin;
        if (expectResult) q8.push_back(model8(a, b, bin));
        tick();
        if8.start = 1'b0;
    endtask

    task automatic waitDone8(input string tag, input int bound);
        int n;
        n = 0;
        while (!if8.done && n < bound) begin
            tick();
            n++;
        end
        checkOutput(tag, {31'd0, if8.done}, 32'd1);
    endtask

    task automatic waitDone4(input string tag, input int bound);
        int n;
        n = 0;
        while (!if4.done && n < bound) begin
            tick();
            n++;
        end
        checkOutput(tag, {31'd0, if4.done}, 32'd1);
    endtask

    always @(negedge clk) begin
        if (rst_n && if8.done) begin
            doneCount8++;
            checkOutput("sb8_has_entry", {31'd0, (q8.size() != 0)}, 32'd1);
            if (q8.size() != 0) begin
                exp_t e;
                e = q8.pop_front();
                checkOutput("diff8", {24'd0, if8.diff}, {24'd0, e.d});
                checkOutput("borrow8", {31'd0, if8.borrow_out}, {31'd0, e.br});
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && if4.done) begin
            doneCount4++;
            checkOutput("sb4_has_entry", {31'd0, (q4.size() != 0)}, 32'd1);
            if (q4.size() != 0) begin
                lastExp4 = q4.pop_front();
                checkOutput("diff4", {28'd0, if4.diff}, {24'd0, lastExp4.d});
                checkOutput("borrow4", {31'd0, if4.borrow_out}, {31'd0, lastExp4.br});
            end
        end else if (rst_n && if4.busy) begin
            checkOutput("diff4_stable", {28'd0, if4.diff}, {24'd0, lastExp4.d});
        end
    end

    initial begin
        int base;
        int n;
        int firstDone;
        int secondDone;
        int seen;
        checks      = 0;
        failures    = 0;
        doneCount8  = 0;
        doneCount4  = 0;
        lastExp4.d  = 8'd0;
        lastExp4.br = 1'b0;
        if8.start = 1'b0; if8.a = '0; if8.b = '0; if8.bin = 1'b0;
        if4.start = 1'b0; if4.a = '0; if4.b = '0; if4.bin = 1'b0;

        // Reset state
        rst_n = 1'b0;
        tick();
        tick();
        checkOutput("rst_busy", {31'd0, if8.busy}, 32'd0);
        checkOutput("rst_done", {31'd0, if8.done}, 32'd0);
        checkOutput("rst_diff", {24'd0, if8.diff}, 32'd0);
        checkOutput("rst_borrow", {31'd0, if8.borrow_out}, 32'd0);
        rst_n = 1'b1;
        tick();

        // 5 - 3: busy for exactly 8 cycles, done 8 clocks after the start edge
        applyStimulus(8'd5, 8'd3, 1'b0, 1'b1);
        for (int i = 0; i < 8; i++) begin
            checkOutput("t1_busy", {31'd0, if8.busy}, 32'd1);
            checkOutput("t1_no_done", {31'd0, if8.done}, 32'd0);
            if (i == 7) checkOutput("t1_diff_held", {24'd0, if8.diff}, 32'd0);
            tick();
        end
        checkOutput("t1_done_latency", {31'd0, if8.done}, 32'd1);
        checkOutput("t1_busy_low", {31'd0, if8.busy}, 32'd0);
        tick();
        checkOutput("t1_done_one_cycle", {31'd0, if8.done}, 32'd0);

        // Wrap-around cases
        applyStimulus(8'h00, 8'h01, 1'b0, 1'b1);
        waitDone8("t2a_done", 20);
        tick();
        applyStimulus(8'h80, 8'h80, 1'b1, 1'b1);
        waitDone8("t2b_done", 20);
        tick();

        // Start during RUN is ignored
        base = doneCount8;
        applyStimulus(8'h10, 8'h01, 1'b0, 1'b1);
        tick();
        tick();
        if8.start = 1'b1; if8.a = 8'hFF; if8.b = 8'h00; if8.bin = 1'b1;
        tick();
        if8.start = 1'b0;
        waitDone8("t3_done", 20);
        for (int i = 0; i < 14; i++) tick();
        checkOutput("t3_single_done", doneCount8 - base, 32'd1);

        // Reset in the middle of RUN aborts the operation
        base = doneCount8;
        applyStimulus(8'h33, 8'h11, 1'b0, 1'b0);
        tick();
        tick();
        tick();
        checkOutput("t4_busy_before", {31'd0, if8.busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("t4_busy", {31'd0, if8.busy}, 32'd0);
        checkOutput("t4_done", {31'd0, if8.done}, 32'd0);
        checkOutput("t4_diff", {24'd0, if8.diff}, 32'd0);
        checkOutput("t4_borrow", {31'd0, if8.borrow_out}, 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) tick();
        checkOutput("t4_no_done", doneCount8 - base, 32'd0);
        applyStimulus(8'd9, 8'd4, 1'b1, 1'b1);
        waitDone8("t4_restart_done", 20);
        tick();

        // start held high: back-to-back with one IDLE cycle between
        if8.start = 1'b1; if8.a = 8'hAA; if8.b = 8'h55; if8.bin = 1'b0;
        q8.push_back(model8(8'hAA, 8'h55, 1'b0));
        tick();
        if8.a = 8'h55; if8.b = 8'hAA;
        q8.push_back(model8(8'h55, 8'hAA, 1'b0));
        n = 0; seen = 0; firstDone = 0; secondDone = 0;
        while (seen < 2 && n < 40) begin
            if (if8.done) begin
                seen++;
                if (seen == 1) firstDone = n;
                else secondDone = n;
            end
            if (seen < 2) begin
                tick();
                n++;
            end
        end
        if8.start = 1'b0;
        checkOutput("t5_two_dones", seen, 32'd2);
        checkOutput("t5_spacing", secondDone - firstDone, 32'd10);
        for (int i = 0; i < 4; i++) tick();
        checkOutput("t5_stopped", {31'd0, if8.busy}, 32'd0);

        // WIDTH=4 exhaustive sweep
        for (int ai = 0; ai < 16; ai++) begin
            for (int bi = 0; bi < 16; bi++) begin
                for (int ci = 0; ci < 2; ci++) begin
                    logic [4:0] r;
                    logic [3:0] av;
                    logic [3:0] bv;
                    exp_t e;
                    av = 4'(ai);
                    bv = 4'(bi);
                    r  = {1'b0, av} - {1'b0, bv} - 5'(ci);
                    e.d  = {4'd0, r[3:0]};
                    e.br = r[4];
                    q4.push_back(e);
                    if4.start = 1'b1; if4.a = av; if4.b = bv; if4.bin = ci[0];
                    tick();
                    if4.start = 1'b0;
                    waitDone4("t6_done", 10);
                    tick();
                end
            end
        end
        checkOutput("t6_count", doneCount4, 32'd512);

        checkOutput("q8_drained", q8.size(), 32'd0);
        checkOutput("q4_drained", q4.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
